// File: rtl/chord_cmd_decoder_pkg.sv
// Shared calculator definitions: chord FSM states, ucode command codes and the
// default 4-button chord-to-command map.
package calc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RPT,
    S_WAIT_REL
  } state_t;

  typedef enum logic [3:0] {
    ST_NOP = 4'd0,
    ST_PSH = 4'd1,
    ST_POP = 4'd2,
    ST_ADD = 4'd3,
    ST_SUB = 4'd4,
    ST_TOP = 4'd5,
    ST_RST = 4'd6,
    ST_INC = 4'd7,
    ST_DEC = 4'd8
  } st_cmd_t;

  // Bits 0/1 are the action buttons, bits 2/3 the modifiers.
  function automatic st_cmd_t chord_to_cmd(input logic [3:0] i_chord);
    case (i_chord)
      4'd1:    return ST_PSH;
      4'd2:    return ST_POP;
      4'd5:    return ST_ADD;
      4'd6:    return ST_SUB;
      4'd9:    return ST_TOP;
      4'd10:   return ST_RST;
      4'd13:   return ST_INC;
      4'd14:   return ST_DEC;
      default: return ST_NOP;
    endcase
  endfunction

endpackage

// File: rtl/chord_cmd_decoder_debounce.sv
// Single-button debouncer: the accepted level follows the input only after
// DB_SAMPLES consecutive ticks at the new level.
module btn_debounce #(
  parameter int DB_SAMPLES = 4
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iTick,
  input  logic iBtn,
  output logic oBtn
);

  localparam int CW = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_level;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (iTick) begin
      if (iBtn == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_SAMPLES - 1)) begin
        r_level <= iBtn;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign oBtn = r_level;

endmodule

// File: rtl/chord_cmd_decoder.sv
// Button-chord command front end: debounces the buttons, latches one action plus
// modifiers, and hands the chord to the ucode sequencer on a valid/ready port.
module chord_cmd_decoder
  import calc_pkg::*;
#(
  parameter int                   NUM_BTNS   = 4,
  parameter logic [NUM_BTNS-1:0]  MOD_MASK   = NUM_BTNS'('hC),
  parameter int                   TICK_DIV   = 25000,
  parameter int                   DB_SAMPLES = 4,
  parameter int                   RPT_EN     = 0,
  parameter int                   RPT_DELAY  = 50,
  parameter int                   RPT_PERIOD = 10
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic [NUM_BTNS-1:0] iBtns,
  input  logic                iCmdReady,
  output logic                oCmdValid,
  output logic [NUM_BTNS-1:0] oChord,
  output logic                oRepeat,
  output logic                oOvf,
  output logic [NUM_BTNS-1:0] oBtnsDb
);

  localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RMAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [NUM_BTNS-1:0] r_sync1, r_sync2;
  logic [TW-1:0]       r_tick_cnt;
  logic                w_tick;
  logic [NUM_BTNS-1:0] w_db, w_act, w_mod;

  // NOTE: non-blocking assignments let each stage sample the previous stage's old value.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= iBtns;
      r_sync2    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
    btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db (
      .iClk  (iClk),
      .iRst  (iRst),
      .iTick (w_tick),
      .iBtn  (r_sync2[g]),
      .oBtn  (w_db[g])
    );
  end

  assign w_act = w_db & ~MOD_MASK;
  assign w_mod = w_db & MOD_MASK;

  state_t              r_state, w_state_nxt;
  logic [NUM_BTNS-1:0] r_chord, w_chord_nxt;
  logic [RW-1:0]       r_rpt_cnt;
  logic                w_emit, w_emit_rpt, w_rpt_clr;
  logic                w_held_act, w_other_act;
  logic                r_valid, r_rpt, r_ovf;
  logic [NUM_BTNS-1:0] r_out_chord;

  // r_chord only ever carries a single action bit, so these split "same" from "another".
  assign w_held_act  = |(w_act & r_chord);
  assign w_other_act = |(w_act & ~r_chord);

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_chord_nxt = r_chord;
    w_emit      = 1'b0;
    w_emit_rpt  = 1'b0;
    w_rpt_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ($countones(w_act) == 1) begin
          w_state_nxt = S_HOLD;
          w_chord_nxt = w_act | w_mod;
        end else if ($countones(w_act) > 1) begin
          w_state_nxt = S_WAIT_REL;
        end
      end
      S_HOLD: begin
        w_chord_nxt = r_chord | w_mod;
        if (w_other_act) begin
          w_state_nxt = S_WAIT_REL;
          w_chord_nxt = '0;
        end else if (!w_held_act) begin
          w_emit      = 1'b1;
          w_state_nxt = S_IDLE;
        end else if ((RPT_EN != 0) && w_tick && (r_rpt_cnt == RW'(RPT_DELAY - 1))) begin
          w_emit      = 1'b1;
          w_emit_rpt  = 1'b1;
          w_state_nxt = S_RPT;
        end
      end
      S_RPT: begin
        if (w_other_act) begin
          w_state_nxt = S_WAIT_REL;
          w_chord_nxt = '0;
        end else if (!w_held_act) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick && (r_rpt_cnt == RW'(RPT_PERIOD - 1))) begin
          w_emit     = 1'b1;
          w_emit_rpt = 1'b1;
          w_rpt_clr  = 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (w_act == '0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state   <= S_IDLE;
      r_chord   <= '0;
      r_rpt_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_chord <= w_chord_nxt;
      if ((w_state_nxt != r_state) || w_rpt_clr) begin
        r_rpt_cnt <= '0;
      end else if (w_tick && (r_rpt_cnt != RW'(RMAX))) begin
        r_rpt_cnt <= r_rpt_cnt + 1'b1;
      end
    end
  end

  // A new command may replace the pending one only in the cycle it is accepted.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_valid     <= 1'b0;
      r_rpt       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_chord <= '0;
    end else if (w_emit) begin
      if (!r_valid || iCmdReady) begin
        r_valid     <= 1'b1;
        r_out_chord <= w_chord_nxt;
        r_rpt       <= w_emit_rpt;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (r_valid && iCmdReady) begin
      r_valid <= 1'b0;
    end
  end

  assign oCmdValid = r_valid;
  assign oChord    = r_out_chord;
  assign oRepeat   = r_rpt;
  assign oOvf      = r_ovf;
  assign oBtnsDb   = w_db;

endmodule

// File: tb/tb_chord_cmd_decoder.sv
// Self-checking bench for chord_cmd_decoder: chord vectors, timing sequences and a
// randomized run scored against a pattern-level reference model.
module tb_chord_cmd_decoder;
  import calc_pkg::*;

  localparam int         TD   = 4;
  localparam int         DBS  = 3;
  localparam int         RD   = 5;
  localparam int         RP   = 2;
  localparam logic [3:0] MODS = 4'hC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b1;
  logic [3:0] btns = 4'b0000;

  logic       m_valid, m_rpt, m_ovf;
  logic [3:0] m_chord, m_db;
  logic       r_valid, r_rpt, r_ovf;
  logic [3:0] r_chord, r_db;

  always #5 clk = ~clk;

  chord_cmd_decoder #(
    .NUM_BTNS(4), .MOD_MASK(MODS), .TICK_DIV(TD), .DB_SAMPLES(DBS),
    .RPT_EN(0), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) u_dut (
    .iClk(clk), .iRst(rst), .iBtns(btns), .iCmdReady(ready),
    .oCmdValid(m_valid), .oChord(m_chord), .oRepeat(m_rpt), .oOvf(m_ovf), .oBtnsDb(m_db)
  );

  chord_cmd_decoder #(
    .NUM_BTNS(4), .MOD_MASK(MODS), .TICK_DIV(TD), .DB_SAMPLES(DBS),
    .RPT_EN(1), .RPT_DELAY(RD), .RPT_PERIOD(RP)
  ) u_dut_rpt (
    .iClk(clk), .iRst(rst), .iBtns(btns), .iCmdReady(ready),
    .oCmdValid(r_valid), .oChord(r_chord), .oRepeat(r_rpt), .oOvf(r_ovf), .oBtnsDb(r_db)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] chord;
    logic       rpt;
    int         cyc;
  } cmd_t;

  cmd_t q_main[$];
  cmd_t q_rpt[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Accepted commands are logged at the falling edge, between input changes and the next edge.
  always @(negedge clk) begin
    if (m_valid && ready) q_main.push_back('{m_chord, m_rpt, cyc});
    if (r_valid && ready) q_rpt.push_back('{r_chord, r_rpt, cyc});
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold_watch(input logic [3:0] p, input int n, input logic [3:0] chord_exp,
                            output bit stable);
    btns   = p;
    stable = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (!(m_valid && (m_chord == chord_exp))) stable = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] p0, p1, p2, p3;
    int         n;
    logic [3:0] c0, c1;
    st_cmd_t    k0;
  } vec_t;

  vec_t vecs[10];

  // Reference model state: advanced once per stable button pattern.
  logic [3:0] mdl_held;
  bit         mdl_blocked;
  logic [3:0] mdl_chord;
  logic [3:0] mdl_exp[$];

  task automatic model_step(input logic [3:0] p);
    logic [3:0] a, m;
    a = p & ~MODS;
    m = p & MODS;
    if (mdl_blocked) begin
      if (a == 4'b0000) mdl_blocked = 1'b0;
    end else if (mdl_held == 4'b0000) begin
      if ($countones(a) == 1) begin
        mdl_held  = a;
        mdl_chord = a | m;
      end else if (a != 4'b0000) begin
        mdl_blocked = 1'b1;
      end
    end else begin
      mdl_chord = mdl_chord | m;
      if ((a & ~mdl_held) != 4'b0000) begin
        mdl_held    = 4'b0000;
        mdl_blocked = 1'b1;
      end else if (a == 4'b0000) begin
        mdl_exp.push_back(mdl_chord);
        mdl_held = 4'b0000;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         base, n_got, exp_n, c_rise, c_fall, d;
    bit         found, stable_a, stable_b;
    logic [3:0] seen, p;
    logic [3:0] pats[4];

    vecs[0] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, ST_PSH};
    vecs[1] = '{4'b0100, 4'b0101, 4'b0001, 4'b0000, 1, 4'b0101, 4'b0000, ST_ADD};
    vecs[2] = '{4'b1000, 4'b1001, 4'b1000, 4'b0000, 1, 4'b1001, 4'b0000, ST_TOP};
    vecs[3] = '{4'b0011, 4'b0000, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, ST_POP};
    vecs[4] = '{4'b0010, 4'b1010, 4'b0010, 4'b0000, 1, 4'b1010, 4'b0000, ST_RST};
    vecs[5] = '{4'b1101, 4'b1100, 4'b0000, 4'b0000, 1, 4'b1101, 4'b0000, ST_INC};
    vecs[6] = '{4'b0100, 4'b0101, 4'b0100, 4'b0110, 2, 4'b0101, 4'b0110, ST_ADD};
    vecs[7] = '{4'b0001, 4'b0011, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, ST_NOP};
    vecs[8] = '{4'b1100, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, ST_NOP};
    vecs[9] = '{4'b0011, 4'b0001, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, ST_NOP};

    // Reset state
    wait_cyc(3);
    @(negedge clk);
    check("reset_main", 32'({m_valid, m_rpt, m_ovf, m_chord, m_db}), 32'd0);
    check("reset_rpt", 32'({r_valid, r_rpt, r_ovf, r_chord, r_db}), 32'd0);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(4);

    // Single press: command one cycle after the debounced release
    btns = 4'b0001;
    wait_cyc(6 * TD);
    @(negedge clk);
    check("t1_db_high", 32'(m_db), 32'h1);
    btns = 4'b0000;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!m_db[0]) found = 1'b1;
    end
    check("t1_db_fall_seen", 32'(found), 32'd1);
    check("t1_valid_at_fall", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_next", 32'(m_valid), 32'd1);
    check("t1_chord", 32'(m_chord), 32'h1);
    check("t1_repeat", 32'(m_rpt), 32'd0);
    wait_cyc(4 * TD);

    // Bounce on button 1 never reaches the debounced level
    base = q_main.size();
    seen = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      btns[1] = ~btns[1];
      repeat (3) begin
        @(negedge clk);
        seen |= m_db;
      end
    end
    btns = 4'b0000;
    repeat (6 * TD) begin
      @(negedge clk);
      seen |= m_db;
    end
    check("bounce_db", 32'(seen), 32'd0);
    check("bounce_cmd", 32'(q_main.size() - base), 32'd0);
    wait_cyc(1);

    // Chord vector table
    foreach (vecs[v]) begin
      base = q_main.size();
      pats = '{vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3};
      for (int k = 0; k < 4; k++) begin
        btns = pats[k];
        wait_cyc(6 * TD);
      end
      btns = 4'b0000;
      wait_cyc(6 * TD);
      n_got = q_main.size() - base;
      check($sformatf("vec%0d_count", v), 32'(n_got), 32'(vecs[v].n));
      if (n_got == vecs[v].n && n_got >= 1) begin
        check($sformatf("vec%0d_chord0", v), 32'(q_main[base].chord), 32'(vecs[v].c0));
        check($sformatf("vec%0d_rpt0", v), 32'(q_main[base].rpt), 32'd0);
        check($sformatf("vec%0d_cmd0", v), 32'(chord_to_cmd(q_main[base].chord)), 32'(vecs[v].k0));
      end
      if (n_got == vecs[v].n && n_got >= 2) begin
        check($sformatf("vec%0d_chord1", v), 32'(q_main[base + 1].chord), 32'(vecs[v].c1));
      end
    end

    // Randomized stable patterns against the reference model
    mdl_held    = 4'b0000;
    mdl_blocked = 1'b0;
    mdl_chord   = 4'b0000;
    base = q_main.size();
    for (int i = 0; i < 30; i++) begin
      p    = 4'($urandom_range(0, 15));
      btns = p;
      wait_cyc(7 * TD);
      model_step(p);
    end
    btns = 4'b0000;
    wait_cyc(7 * TD);
    model_step(4'b0000);
    n_got = q_main.size() - base;
    check("rnd_count", 32'(n_got), 32'(mdl_exp.size()));
    for (int i = 0; i < n_got && i < mdl_exp.size(); i++) begin
      check($sformatf("rnd_chord%0d", i), 32'(q_main[base + i].chord), 32'(mdl_exp[i]));
      check($sformatf("rnd_rpt%0d", i), 32'(q_main[base + i].rpt), 32'd0);
    end
    check("rnd_ovf", 32'(m_ovf), 32'd0);

    // Auto-repeat timing on the RPT_EN=1 instance
    base = q_rpt.size();
    btns = 4'b0001;
    found = 1'b0;
    c_rise = 0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (r_db[0]) begin
        found  = 1'b1;
        c_rise = cyc;
      end
    end
    check("rpt_rise_seen", 32'(found), 32'd1);
    wait_cyc(40 * TD);
    btns = 4'b0000;
    found = 1'b0;
    c_fall = c_rise;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (!r_db[0]) begin
        found  = 1'b1;
        c_fall = cyc;
      end
    end
    check("rpt_fall_seen", 32'(found), 32'd1);
    wait_cyc(10 * TD);
    d     = (c_fall - c_rise) / TD;
    exp_n = (d >= RD) ? ((d - RD) / RP + 1) : 0;
    n_got = q_rpt.size() - base;
    check("rpt_count", 32'(n_got), 32'(exp_n));
    for (int k = 0; k < n_got && k < exp_n; k++) begin
      check($sformatf("rpt%0d_cycle", k), 32'(q_rpt[base + k].cyc), 32'(c_rise + TD * (RD + RP * k)));
      check($sformatf("rpt%0d_flag", k), 32'(q_rpt[base + k].rpt), 32'd1);
      check($sformatf("rpt%0d_chord", k), 32'(q_rpt[base + k].chord), 32'h1);
    end

    // Overflow with the consumer stalled, then reset in the middle of a hold
    ready = 1'b0;
    base  = q_main.size();
    btns  = 4'b0001;
    wait_cyc(6 * TD);
    btns = 4'b0000;
    wait_cyc(6 * TD);
    @(negedge clk);
    check("ovf_first_valid", 32'(m_valid), 32'd1);
    check("ovf_first_chord", 32'(m_chord), 32'h1);
    check("ovf_before_drop", 32'(m_ovf), 32'd0);
    hold_watch(4'b0010, 6 * TD, 4'b0001, stable_a);
    hold_watch(4'b0000, 6 * TD, 4'b0001, stable_b);
    check("ovf_chord_stable", 32'(stable_a && stable_b), 32'd1);
    check("ovf_sticky", 32'(m_ovf), 32'd1);
    check("ovf_repeat", 32'(m_rpt), 32'd0);
    wait_cyc(1);
    btns = 4'b0001;
    wait_cyc(6 * TD);
    @(negedge clk);
    check("pre_rst_db", 32'(m_db), 32'h1);
    wait_cyc(1);
    rst = 1'b1;
    #1;
    check("rst_async", 32'({m_valid, m_rpt, m_ovf, m_chord, m_db}), 32'd0);
    wait_cyc(2);
    rst   = 1'b0;
    ready = 1'b1;
    wait_cyc(5);
    btns = 4'b0000;
    wait_cyc(10 * TD);
    @(negedge clk);
    check("rst_no_cmd", 32'(q_main.size() - base), 32'd0);
    check("rst_idle_outputs", 32'({m_valid, m_ovf, m_db}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
